// File: rtl/task_11_pkg.sv
// Shared definitions for the task 11 output collector: FSM state encoding,
// output beat width and the frame byte-count helper.
package task_11_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        s_IDLE    = 3'd0,
        s_COLLECT = 3'd1,
        s_FLUSH   = 3'd2,
        s_SEND    = 3'd3,
        s_DONE    = 3'd4
    } task_output_enum;

    function automatic int bytes_per_frame(input int n);
        return (n + 7) / 8;
    endfunction

endpackage

// File: rtl/task_11_out_fifo.sv
// Synchronous byte FIFO with a registered read port (1-cycle read latency).
// The read data register holds its value until the next accepted read.
module task_11_out_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_wr;
    logic             do_rd;

    assign o_empty = (count == '0);
    assign o_full  = (count == CNTW'(DEPTH));
    assign do_wr   = i_wr_en && !o_full;
    assign do_rd   = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr    <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
                o_rd_data <= mem[rd_ptr];
            end
            if (do_wr && !do_rd) begin
                count <= count + CNTW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/task_11_out.sv
// Task 11 output collector: packs sample bits LSB-first into bytes and streams one frame.
// Define TASK_11_OUT_TRAILER_EN to append an XOR-of-data trailer beat carrying o_tdata_last.
module task_11_out
    import task_11_pkg::*;
#(
    parameter int NUM_SAMPLES = 243,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enb,
    input  logic                  i_sample,
    input  logic                  i_tready,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tdata_valid,
    output logic                  o_tdata_last,
    output logic                  o_output_last,
    output logic                  o_drop
);

    localparam int CW         = $clog2(NUM_SAMPLES + 1);
    localparam int DATA_BYTES = bytes_per_frame(NUM_SAMPLES);
`ifdef TASK_11_OUT_TRAILER_EN
    localparam int FRAME_BEATS = DATA_BYTES + 1;
`else
    localparam int FRAME_BEATS = DATA_BYTES;
`endif
    localparam int BW = $clog2(FRAME_BEATS + 1);

    localparam logic [CW-1:0] LAST_SAMPLE = CW'(NUM_SAMPLES - 1);
    localparam logic [BW-1:0] BEATS_C     = BW'(FRAME_BEATS);
    localparam logic [BW-1:0] LAST_BEAT   = BW'(FRAME_BEATS - 1);

    task_output_enum       state;
    logic [CW-1:0]         sample_cnt;
    logic [2:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] pack;
    logic [DATA_WIDTH-1:0] pack_next;
    logic                  sample_take;
    logic                  byte_done;
    logic                  last_sample;

    logic                  wr_req;
    logic                  fifo_wr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  fifo_empty;
    logic                  fifo_full;

    logic                  rd_valid;
    logic [BW-1:0]         reads_issued;
    logic [BW-1:0]         beats_loaded;
    logic                  accept;
    logic                  load;

`ifdef TASK_11_OUT_TRAILER_EN
    logic [DATA_WIDTH-1:0] xor_acc;
    logic                  trailer_pending;
`endif

    assign sample_take = (state == s_COLLECT) && i_enb;
    assign byte_done   = (bit_cnt == 3'd7);
    assign last_sample = (sample_cnt == LAST_SAMPLE);
    assign pack_next   = pack | (DATA_WIDTH'(i_sample) << bit_cnt);

    always_comb begin
        wr_req  = 1'b0;
        wr_data = pack_next;
        if (sample_take && byte_done) begin
            wr_req = 1'b1;
        end else if (state == s_FLUSH) begin
            wr_req  = 1'b1;
            wr_data = pack;
`ifdef TASK_11_OUT_TRAILER_EN
        end else if ((state == s_SEND) && trailer_pending) begin
            wr_req  = 1'b1;
            wr_data = xor_acc;
`endif
        end
    end

    assign fifo_wr = wr_req && !fifo_full;

    // Two-stage read pipeline: FIFO read register, then the output register.
    // A new read is issued only when the FIFO read register will be free.
    assign accept = o_tdata_valid && i_tready;
    assign load   = (state == s_SEND) && rd_valid && (!o_tdata_valid || accept);
    assign rd_en  = (state == s_SEND) && !fifo_empty && (reads_issued != BEATS_C)
                    && (!rd_valid || load);

    task_11_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (fifo_wr),
        .i_wr_data (wr_data),
        .i_rd_en   (rd_en),
        .o_rd_data (rd_data),
        .o_empty   (fifo_empty),
        .o_full    (fifo_full)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= s_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            pack       <= '0;
        end else begin
            case (state)
                s_IDLE: begin
                    state      <= s_COLLECT;
                    sample_cnt <= '0;
                    bit_cnt    <= '0;
                    pack       <= '0;
                end
                s_COLLECT: begin
                    if (sample_take) begin
                        sample_cnt <= sample_cnt + CW'(1);
                        bit_cnt    <= bit_cnt + 3'd1;
                        pack       <= byte_done ? '0 : pack_next;
                        if (last_sample) begin
                            state <= byte_done ? s_SEND : s_FLUSH;
                        end
                    end
                end
                s_FLUSH: begin
                    pack  <= '0;
                    state <= s_SEND;
                end
                s_SEND: begin
                    if (accept && o_tdata_last) begin
                        state <= s_DONE;
                    end
                end
                s_DONE:  state <= s_IDLE;
                default: state <= s_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid      <= 1'b0;
            reads_issued  <= '0;
            beats_loaded  <= '0;
            o_tdata       <= '0;
            o_tdata_valid <= 1'b0;
            o_tdata_last  <= 1'b0;
            o_output_last <= 1'b0;
            o_drop        <= 1'b0;
        end else begin
            o_output_last <= (state == s_SEND) && accept && o_tdata_last;
            o_drop        <= o_drop || (i_enb && (state != s_COLLECT));
            if (state == s_IDLE) begin
                rd_valid     <= 1'b0;
                reads_issued <= '0;
                beats_loaded <= '0;
            end else begin
                if (rd_en) begin
                    rd_valid     <= 1'b1;
                    reads_issued <= reads_issued + BW'(1);
                end else if (load) begin
                    rd_valid <= 1'b0;
                end
                if (load) begin
                    o_tdata       <= rd_data;
                    o_tdata_valid <= 1'b1;
                    o_tdata_last  <= (beats_loaded == LAST_BEAT);
                    beats_loaded  <= beats_loaded + BW'(1);
                end else if (accept) begin
                    o_tdata_valid <= 1'b0;
                    o_tdata_last  <= 1'b0;
                end
            end
        end
    end

`ifdef TASK_11_OUT_TRAILER_EN
    // The trailer is written on the first SEND cycle, after every data byte is in the FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            xor_acc         <= '0;
            trailer_pending <= 1'b0;
        end else if (state == s_IDLE) begin
            xor_acc         <= '0;
            trailer_pending <= 1'b1;
        end else begin
            if (fifo_wr && (state != s_SEND)) begin
                xor_acc <= xor_acc ^ wr_data;
            end
            if (state == s_SEND) begin
                trailer_pending <= 1'b0;
            end
        end
    end
`endif

    // A write into a full FIFO means FIFO_DEPTH is too small for the frame.
    assert property (@(posedge i_clk) disable iff (!i_rst_n) !(wr_req && fifo_full));

endmodule
